// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
// Contents: OP_W (opcode width) and op_e (operation codes; 3'b101..3'b111 reserved).
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD     = 3'b000,
        OP_ADD_X2  = 3'b001,
        OP_SUB     = 3'b010,
        OP_ACC     = 3'b011,
        OP_ACC_CLR = 3'b100
    } op_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational arithmetic for one ALU beat, evaluated in WIDTH+2 bits.
// Ports:
//   op       in  OP_W     operation code (op_e encoding, reserved codes give 0)
//   a, b     in  WIDTH    unsigned operands
//   acc      in  WIDTH+1  current accumulator value
//   o        out WIDTH+1  result R[WIDTH:0]
//   c        out 1        carry/borrow R[WIDTH+1]
//   acc_next out WIDTH+1  accumulator value to load
//   acc_we   out 1        accumulator load request (ACC / ACC_CLR)
// Macro ALU_PIPE_SAT_EN: saturating results instead of wrap-around.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH:0]   acc,
    output logic [WIDTH:0]   o,
    output logic             c,
    output logic [WIDTH:0]   acc_next,
    output logic             acc_we
);

    localparam int unsigned RW = WIDTH + 2;

    op_e          op_i;
    logic [RW-1:0] a_x;
    logic [RW-1:0] b_x;
    logic [RW-1:0] acc_x;
    logic [RW-1:0] r;

    // Raw result select, then optional saturation override.
    always_comb begin
        op_i     = op_e'(op);
        a_x      = RW'(a);
        b_x      = RW'(b);
        acc_x    = RW'(acc);
        r        = '0;
        acc_we   = 1'b0;
        case (op_i)
            OP_ADD:     r = a_x + b_x;
            OP_ADD_X2:  r = (a_x + b_x) << 1;
            OP_SUB:     r = a_x - b_x;
            OP_ACC: begin
                r      = acc_x + a_x + b_x;
                acc_we = 1'b1;
            end
            OP_ACC_CLR: begin
                r      = '0;
                acc_we = 1'b1;
            end
            default:    r = '0;
        endcase
        o        = r[WIDTH:0];
        c        = r[RW-1];
        acc_next = r[WIDTH:0];
`ifdef ALU_PIPE_SAT_EN
        // Top bit set means overflow for the adds and a negative difference for SUB.
        if (r[RW-1] && (op_i == OP_ADD || op_i == OP_ADD_X2 || op_i == OP_ACC)) begin
            o        = '1;
            c        = 1'b1;
            acc_next = '1;
        end
        if (r[RW-1] && op_i == OP_SUB) begin
            o = '0;
            c = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready on both sides and a running accumulator.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand beat handshake (in_ready is combinational)
//   op, a, b            operation code and unsigned operands
//   out_valid/out_ready result handshake
//   o, c                result R[WIDTH:0] and carry/borrow R[WIDTH+1]
// Macro ALU_PIPE_SAT_EN: saturating results (handled inside alu_core).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   o,
    output logic             c
);

    logic             s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]  s1_op_q,    s1_op_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH:0]   o_q, o_d;
    logic             c_q, c_d;
    logic [WIDTH:0]   acc_q, acc_d;

    logic             adv1_c, adv2_c;
    logic [WIDTH:0]   core_o_c;
    logic             core_c_c;
    logic [WIDTH:0]   core_acc_next_c;
    logic             core_acc_we_c;

    // Stage advance: stage 2 moves when empty or drained; stage 1 when empty or stage 2 moves.
    always_comb begin
        adv2_c = !out_valid_q || out_ready;
        adv1_c = !s1_valid_q || adv2_c;
    end

    assign in_ready  = adv1_c;
    assign out_valid = out_valid_q;
    assign o         = o_q;
    assign c         = c_q;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op       (s1_op_q),
        .a        (s1_a_q),
        .b        (s1_b_q),
        .acc      (acc_q),
        .o        (core_o_c),
        .c        (core_c_c),
        .acc_next (core_acc_next_c),
        .acc_we   (core_acc_we_c)
    );

    // Next-state for both stages; acc only moves with an ACC/ACC_CLR beat entering stage 2.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        out_valid_d = out_valid_q;
        o_d         = o_q;
        c_d         = c_q;
        acc_d       = acc_q;
        if (adv1_c) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d = op;
                s1_a_d  = a;
                s1_b_d  = b;
            end
        end
        if (adv2_c) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                o_d = core_o_c;
                c_d = core_c_c;
                if (core_acc_we_c) begin
                    acc_d = core_acc_next_c;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            out_valid_q <= 1'b0;
            o_q         <= '0;
            c_q         <= 1'b0;
            acc_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            out_valid_q <= out_valid_d;
            o_q         <= o_d;
            c_q         <= c_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe (WIDTH=4) against an arithmetic model.
module tb_alu_pipe;
    import alu_pkg::*;

`ifdef ALU_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] o;
    logic       c;

    alu_pipe #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .c         (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp;
    int         n_err;
    logic [5:0] exp_q[$];
    logic [5:0] got_q[$];
    int         m_acc;
    logic       prev_stall;
    logic [4:0] prev_o;
    logic       prev_c;
    logic       s_ov;
    logic       s_ir;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic modulo 2^6, result {c, o}; tracks acc in issue order.
    function automatic logic [5:0] model(input int opv, input int av, input int bv);
        int         r;
        int         rr;
        logic [4:0] ov;
        logic       cv;
        case (opv)
            0:       r = av + bv;
            1:       r = 2 * (av + bv);
            2:       r = av - bv;
            3:       r = m_acc + av + bv;
            default: r = 0;
        endcase
        rr = ((r % 64) + 64) % 64;
        ov = 5'(rr % 32);
        cv = (rr >= 32);
        if (SAT) begin
            if ((opv == 0 || opv == 1 || opv == 3) && cv) ov = 5'h1F;
            if (opv == 2 && av < bv) begin
                ov = 5'h00;
                cv = 1'b1;
            end
        end
        if (opv == 3) m_acc = int'(ov);
        if (opv == 4) m_acc = 0;
        return {cv, ov};
    endfunction

    // One clock cycle: drive at negedge, sample/check 1 time unit later, then the rising edge follows.
    task automatic cycle(input logic v, input logic [2:0] opv, input logic [3:0] av,
                         input logic [3:0] bv, input logic rdy);
        logic [5:0] e;
        @(negedge clk);
        in_valid  = v;
        op        = opv;
        a         = av;
        b         = bv;
        out_ready = rdy;
        #1;
        s_ir = in_ready;
        s_ov = out_valid;
        if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'(1));
            chk("stall_o", 32'(o), 32'(prev_o));
            chk("stall_c", 32'(c), 32'(prev_c));
        end
        chk("in_ready", 32'(in_ready), (exp_q.size() >= 2 && !rdy) ? 32'(0) : 32'(1));
        if (exp_q.size() == 0) chk("idle_valid", 32'(out_valid), 32'(0));
        if (out_valid && rdy && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("result_o", 32'(o), 32'(e[4:0]));
            chk("result_c", 32'(c), 32'(e[5]));
            got_q.push_back({c, o});
        end
        if (v && in_ready) exp_q.push_back(model(int'(opv), int'(av), int'(bv)));
        prev_stall = out_valid && !rdy;
        prev_o     = o;
        prev_c     = c;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycle(1'b0, 3'd0, 4'd0, 4'd0, 1'b1);
        chk("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic single(input string tag, input logic [2:0] opv, input logic [3:0] av,
                          input logic [3:0] bv, input logic [5:0] want);
        got_q.delete();
        cycle(1'b1, opv, av, bv, 1'b1);
        drain();
        chk({tag, "_count"}, 32'(got_q.size()), 32'(1));
        if (got_q.size() == 1) chk(tag, 32'(got_q[0]), 32'(want));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        m_acc      = 0;
        prev_stall = 1'b0;
        prev_o     = '0;
        prev_c     = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        op         = '0;
        a          = '0;
        b          = '0;
        out_ready  = 1'b0;

        // Reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_o", 32'(o), 32'(0));
        chk("rst_c", 32'(c), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Two-register latency, ADD F+F
        got_q.delete();
        cycle(1'b1, OP_ADD, 4'hF, 4'hF, 1'b1);
        cycle(1'b0, 3'd0, 4'd0, 4'd0, 1'b1);
        chk("lat_not_yet", 32'(s_ov), 32'(0));
        cycle(1'b0, 3'd0, 4'd0, 4'd0, 1'b1);
        chk("lat_visible", 32'(s_ov), 32'(1));
        drain();
        chk("add_ff", 32'(got_q.size() > 0 ? got_q[0] : 6'h3F), 32'(6'h1E));

        single("addx2_ff", OP_ADD_X2, 4'hF, 4'hF, SAT ? 6'h3F : 6'h3C);
        single("sub_3_5", OP_SUB, 4'h3, 4'h5, SAT ? 6'h20 : 6'h3E);
        single("sub_5_3", OP_SUB, 4'h5, 4'h3, 6'h02);
        single("reserved", 3'b110, 4'h7, 4'h2, 6'h00);

        // Back-to-back accumulate
        got_q.delete();
        cycle(1'b1, OP_ACC_CLR, 4'h0, 4'h0, 1'b1);
        cycle(1'b1, OP_ACC, 4'h3, 4'h4, 1'b1);
        cycle(1'b1, OP_ACC, 4'hF, 4'hF, 1'b1);
        drain();
        chk("acc_count", 32'(got_q.size()), 32'(3));
        if (got_q.size() == 3) begin
            chk("acc_clr", 32'(got_q[0]), 32'(6'h00));
            chk("acc_7", 32'(got_q[1]), 32'(6'h07));
            chk("acc_wrap", 32'(got_q[2]), SAT ? 32'(6'h3F) : 32'(6'h25));
        end

        // Stream 5 ADDs with 3 cycles of backpressure
        got_q.delete();
        begin
            int sent = 0;
            int cyc = 0;
            logic saw_block = 1'b0;
            while (sent < 5 && cyc < 30) begin
                cycle(1'b1, OP_ADD, 4'(sent + 1), 4'(2 * sent), !(cyc >= 3 && cyc < 6));
                if (!s_ir) saw_block = 1'b1;
                else sent++;
                cyc++;
            end
            chk("stream_sent", 32'(sent), 32'(5));
            chk("stream_blocked", 32'(saw_block), 32'(1));
        end
        drain();
        chk("stream_count", 32'(got_q.size()), 32'(5));
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            chk("stream_val", 32'(got_q[i]), 32'(3 * i + 1));

        // Reset with acc=7 and two beats in flight
        cycle(1'b1, OP_ACC_CLR, 4'h0, 4'h0, 1'b1);
        cycle(1'b1, OP_ACC, 4'h3, 4'h4, 1'b1);
        drain();
        cycle(1'b1, OP_ADD, 4'h1, 4'h2, 1'b0);
        cycle(1'b1, OP_ADD, 4'h3, 4'h4, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_o", 32'(o), 32'(0));
        chk("mid_rst_c", 32'(c), 32'(0));
        chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
        exp_q.delete();
        m_acc      = 0;
        prev_stall = 1'b0;
        in_valid   = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'(1));
        single("acc_after_rst", OP_ACC, 4'h1, 4'h1, 6'h02);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom),
                  4'($urandom), $urandom_range(0, 3) != 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
